// File: rtl/tdc_pair_tx.sv
// Timestamp-pair transmitter: emits a start/stop dval strobe pair per request
// and publishes the interval the downstream differencer should report.
module tdc_pair_tx #(
  parameter int          GAP    = 2,
  parameter int          COOL   = 4,
  parameter logic [19:0] OFFSET = 20'h007F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_start,
  input  logic [19:0] req_interval,
  output logic        dval,
  output logic [19:0] mlt,
  output logic [19:0] exp_data,
  output logic        exp_valid,
  output logic        busy,
  output logic [15:0] pair_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    WAIT_S,
    SEND_B,
    COOL_S
  } state_e;

  localparam logic [15:0] GAP_M1  = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
  localparam logic [15:0] COOL_M1 = (COOL > 0) ? 16'(COOL - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] cool_q, cool_d;
  logic [19:0] stop_q, stop_d;
  logic [19:0] exp_r_q, exp_r_d;
  logic        dval_q, dval_d;
  logic [19:0] mlt_q, mlt_d;
  logic [19:0] exp_data_q, exp_data_d;
  logic        exp_valid_q, exp_valid_d;
  logic [15:0] pair_cnt_q, pair_cnt_d;
  logic        ready_q, ready_d;
  logic        send_b;

  assign req_ready = ready_q & ~rst;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    cool_d      = cool_q;
    stop_d      = stop_q;
    exp_r_d     = exp_r_q;
    dval_d      = 1'b0;
    mlt_d       = mlt_q;
    exp_data_d  = exp_data_q;
    exp_valid_d = 1'b0;
    pair_cnt_d  = pair_cnt_q;
    ready_d     = ready_q;
    send_b      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = SEND_A;
          dval_d  = 1'b1;
          mlt_d   = req_start;
          stop_d  = req_start + req_interval;
          exp_r_d = req_interval + OFFSET;
          ready_d = 1'b0;
        end
      end
      SEND_A: begin
        if (GAP > 0) begin
          state_d = WAIT_S;
          gap_d   = GAP_M1;
        end else begin
          send_b = 1'b1;
        end
      end
      WAIT_S: begin
        if (gap_q == 16'd0) begin
          send_b = 1'b1;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      SEND_B: begin
        if (COOL > 0) begin
          state_d = COOL_S;
          cool_d  = COOL_M1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      COOL_S: begin
        if (cool_q == 16'd0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cool_d = cool_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
    // Stop strobe is committed once the start strobe has gone out
    if (send_b) begin
      state_d     = SEND_B;
      dval_d      = 1'b1;
      mlt_d       = stop_q;
      exp_valid_d = 1'b1;
      exp_data_d  = exp_r_q;
      pair_cnt_d  = pair_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_q       <= 16'd0;
      cool_q      <= 16'd0;
      stop_q      <= 20'd0;
      exp_r_q     <= 20'd0;
      dval_q      <= 1'b0;
      mlt_q       <= 20'd0;
      exp_data_q  <= 20'd0;
      exp_valid_q <= 1'b0;
      pair_cnt_q  <= 16'd0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      cool_q      <= cool_d;
      stop_q      <= stop_d;
      exp_r_q     <= exp_r_d;
      dval_q      <= dval_d;
      mlt_q       <= mlt_d;
      exp_data_q  <= exp_data_d;
      exp_valid_q <= exp_valid_d;
      pair_cnt_q  <= pair_cnt_d;
      ready_q     <= ready_d;
    end
  end

  assign dval      = dval_q;
  assign mlt       = mlt_q;
  assign exp_data  = exp_data_q;
  assign exp_valid = exp_valid_q;
  assign busy      = (state_q != IDLE);
  assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_tdc_pair_tx.sv
// Scoreboard bench for tdc_pair_tx: one instance at GAP=2/COOL=4,
// one at GAP=0/COOL=0; a negedge monitor pops expected strobes.
module tb_tdc_pair_tx;

  localparam logic [19:0] OFF = 20'h007F0;

  typedef struct {
    int          cyc;
    logic [19:0] mlt;
    logic        stop;
    logic [19:0] xd;
  } ent_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        rv[2];
  logic [19:0] rs[2];
  logic [19:0] ri[2];
  logic        rdy[2];
  logic        dv[2];
  logic [19:0] ml[2];
  logic [19:0] xd[2];
  logic        ev[2];
  logic        bz[2];
  logic [15:0] pc[2];

  ent_t        q[2][$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          pulses[2];
  int          evc[2];
  int          dw[2];
  int          viol = 0;
  logic        par[2];
  logic [19:0] sa[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_pair_tx #(.GAP(2), .COOL(4), .OFFSET(OFF)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_start(rs[0]), .req_interval(ri[0]),
    .dval(dv[0]), .mlt(ml[0]),
    .exp_data(xd[0]), .exp_valid(ev[0]),
    .busy(bz[0]), .pair_cnt(pc[0])
  );

  tdc_pair_tx #(.GAP(0), .COOL(0), .OFFSET(OFF)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_start(rs[1]), .req_interval(ri[1]),
    .dval(dv[1]), .mlt(ml[1]),
    .exp_data(xd[1]), .exp_valid(ev[1]),
    .busy(bz[1]), .pair_cnt(pc[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic bad(input string nm, input int d);
    n_chk++;
    n_fail++;
    $display("FAIL %s on dut%0d at cycle %0d", nm, d, cyc);
  endtask

  // Monitor: pops the scoreboard on every strobe, runs a differencer model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        par[d] = 1'b0;
      end else begin
        if (rdy[d] && bz[d]) viol++;
        if (dv[d] === 1'b1) begin
          ent_t e;
          pulses[d]++;
          if (ev[d]) evc[d]++;
          if (q[d].size() == 0) begin
            bad("unexpected strobe", d);
          end else begin
            e = q[d].pop_front();
            chk("strobe cycle", cyc, e.cyc);
            chk("strobe mlt", {12'd0, ml[d]}, {12'd0, e.mlt});
            chk("exp_valid", {31'd0, ev[d]}, {31'd0, e.stop});
            if (e.stop) chk("exp_data", {12'd0, xd[d]}, {12'd0, e.xd});
          end
          if (!par[d]) begin
            sa[d]  = ml[d];
            par[d] = 1'b1;
          end else begin
            par[d] = 1'b0;
            dw[d]++;
            chk("differencer word", {12'd0, 20'(ml[d] - sa[d] + OFF)},
                {12'd0, xd[d]});
          end
        end else if (ev[d] === 1'b1) begin
          bad("exp_valid without dval", d);
        end
      end
    end
  end

  task automatic issue(input int d, input logic [19:0] s,
                       input logic [19:0] iv, input logic [19:0] es,
                       input logic [19:0] ex, input bit hold,
                       output int c);
    int t = 0;
    int gp = (d == 0) ? 2 : 0;
    @(posedge clk); #1;
    rv[d] = 1'b1;
    rs[d] = s;
    ri[d] = iv;
    @(negedge clk);
    while (!rdy[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[d]) begin
      bad("ready timeout", d);
      rv[d] = 1'b0;
      c = -1;
    end else begin
      c = cyc;
      q[d].push_back('{cyc: c + 1, mlt: s, stop: 1'b0, xd: 20'h0});
      q[d].push_back('{cyc: c + 2 + gp, mlt: es, stop: 1'b1, xd: ex});
      @(posedge clk); #1;
      if (!hold) rv[d] = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    int t = 0;
    @(negedge clk);
    while ((q[d].size() != 0 || bz[d]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q[d].size() != 0 || bz[d]) bad("drain timeout", d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2, c3, p0, pcb, e0, d0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; rs[d] = 0; ri[d] = 0;
      pulses[d] = 0; evc[d] = 0; dw[d] = 0; par[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset dval", {31'd0, dv[0]}, 0);
    chk("reset mlt", {12'd0, ml[0]}, 0);
    chk("reset exp_data", {12'd0, xd[0]}, 0);
    chk("reset exp_valid", {31'd0, ev[0]}, 0);
    chk("reset pair_cnt", {16'd0, pc[0]}, 0);
    chk("reset busy", {31'd0, bz[0]}, 0);
    chk("reset ready", {31'd0, rdy[0]}, 1);

    // Basic pair with ready/hold timing
    issue(0, 20'h00100, 20'h00050, 20'h00150, 20'h00840, 0, c);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("ready at N+%0d", k), {31'd0, rdy[0]},
          (k == 9) ? 32'd1 : 32'd0);
    end
    chk("basic pair_cnt", {16'd0, pc[0]}, 1);
    chk("mlt hold", {12'd0, ml[0]}, 32'h00150);
    chk("exp_data hold", {12'd0, xd[0]}, 32'h00840);

    issue(0, 20'hFFFF0, 20'h00020, 20'h00010, 20'h00810, 0, c);
    issue(0, 20'hABCDE, 20'h00000, 20'hABCDE, 20'h007F0, 0, c);
    drain(0);

    // Back-to-back with req_valid held high
    p0  = pulses[0];
    pcb = pc[0];
    issue(0, 20'h00010, 20'h00005, 20'h00015, 20'h007F5, 1, c1);
    issue(0, 20'h00020, 20'h00100, 20'h00120, 20'h008F0, 1, c2);
    issue(0, 20'hFFFFF, 20'h00001, 20'h00000, 20'h007F1, 0, c3);
    drain(0);
    chk("b2b spacing 1", c2 - c1, 9);
    chk("b2b spacing 2", c3 - c2, 9);
    chk("b2b pulses", pulses[0] - p0, 6);
    chk("b2b pair_cnt", {16'd0, pc[0]} - pcb, 3);

    // Reset in the WAIT state suppresses the stop strobe
    issue(0, 20'h00200, 20'h00010, 20'h00210, 20'h00800, 0, c);
    @(posedge clk); #1;
    rst = 1;
    q[0].delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst-wait dval", {31'd0, dv[0]}, 0);
    chk("rst-wait mlt", {12'd0, ml[0]}, 0);
    chk("rst-wait busy", {31'd0, bz[0]}, 0);
    chk("rst-wait pair_cnt", {16'd0, pc[0]}, 0);
    repeat (6) @(negedge clk);
    issue(0, 20'h00100, 20'h00050, 20'h00150, 20'h00840, 0, c);
    drain(0);
    chk("post-rst pair_cnt", {16'd0, pc[0]}, 1);

    // GAP=0, COOL=0 instance
    d0 = dw[1];
    issue(1, 20'h00300, 20'h00004, 20'h00304, 20'h007F4, 0, c);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      chk($sformatf("gap0 ready at N+%0d", k), {31'd0, rdy[1]},
          (k == 3) ? 32'd1 : 32'd0);
    end
    chk("gap0 differencer words", dw[1] - d0, 1);

    // pair_cnt wrap from a preloaded value
    @(posedge clk); #1;
    force u_dut1.pair_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release u_dut1.pair_cnt_q;
    e0 = evc[1];
    issue(1, 20'h00001, 20'h00002, 20'h00003, 20'h007F2, 0, c);
    drain(1);
    chk("wrap pair_cnt FFFF", {16'd0, pc[1]}, 32'hFFFF);
    issue(1, 20'h00004, 20'h00002, 20'h00006, 20'h007F2, 0, c);
    drain(1);
    chk("wrap pair_cnt 0", {16'd0, pc[1]}, 0);
    issue(1, 20'h00007, 20'h00002, 20'h00009, 20'h007F2, 0, c);
    drain(1);
    chk("wrap pair_cnt 1", {16'd0, pc[1]}, 1);
    chk("exp_valid count", evc[1] - e0, 3);

    drain(0);
    chk("ready while busy", viol, 0);
    chk("queue0 empty", q[0].size(), 0);
    chk("queue1 empty", q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
